// File: rtl/intra_mode_writer.sv
// Intra mode decision stage: sequential argmin over per-mode SADs, row-wise
// writeback of the winning residue block, and a per-block chosen-mode table.
module intra_mode_writer #(
  parameter int NMODES   = 8,
  parameter int SAD_W    = 16,
  parameter int PIX_W    = 8,
  parameter int BLK      = 4,
  parameter int FRAME_W  = 256,
  parameter int FRAME_H  = 256,
  localparam int MODE_W  = (NMODES > 1) ? $clog2(NMODES) : 1,
  localparam int BPR     = FRAME_W / BLK,
  localparam int NBLK    = BPR * (FRAME_H / BLK),
  localparam int BN_W    = $clog2(NBLK),
  localparam int AD_W    = $clog2(FRAME_W * FRAME_H),
  localparam int ROW_W   = BLK * PIX_W,
  localparam int RES_W   = NMODES * BLK * BLK * PIX_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NMODES*SAD_W-1:0] sads,
  input  logic [RES_W-1:0]        residues,
  input  logic [BN_W-1:0]         blk_num,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [AD_W-1:0]         wr_addr,
  output logic [ROW_W-1:0]        wr_data,
  output logic                    mode_valid,
  output logic [MODE_W-1:0]       mode,
  output logic [BN_W-1:0]         mode_blk,
  output logic                    err,
  input  logic [BN_W-1:0]         mtab_raddr,
  output logic [MODE_W-1:0]       mtab_rdata
);

  localparam int RW_W = (BLK > 1) ? $clog2(BLK) : 1;
  localparam logic [BN_W:0] BPR_V  = (BN_W+1)'(BPR);
  localparam logic [BN_W:0] NBLK_V = (BN_W+1)'(NBLK);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, WRITE = 2'd2} state_t;

  // Rows of one mode are contiguous, so a row is a single ROW_W slice.
  function automatic logic [ROW_W-1:0] row_of(input logic [RES_W-1:0] res,
                                              input logic [MODE_W-1:0] m,
                                              input logic [RW_W-1:0]   r);
    return res[(int'(m) * BLK + int'(r)) * ROW_W +: ROW_W];
  endfunction

  state_t                  state_r, state_s;
  logic [NMODES*SAD_W-1:0] sads_r;
  logic [RES_W-1:0]        res_r, res_sel_s;
  logic [BN_W-1:0]         blk_r, blk_sel_s, mode_blk_r;
  logic [BN_W:0]           bx_s, by_s;
  logic [AD_W-1:0]         base_s, addr_s, wr_addr_r;
  logic [ROW_W-1:0]        data_s, wr_data_r;
  logic [MODE_W-1:0]       best_r, best_s, k_r, k_s, mode_r, mtab_rdata_r;
  logic [RW_W-1:0]         row_r, row_s;
  logic                    oor_r, oor_in_s, oor_sel_s;
  logic                    accept_s, load_s, enter_s, last_s, drop_s;
  logic                    in_ready_r, wr_valid_r, mode_valid_r, err_r;
  logic [MODE_W-1:0]       mtab_r [NBLK];

  // Next-state and per-cycle control strobes
  always_comb begin
    state_s  = state_r;
    best_s   = best_r;
    k_s      = k_r;
    row_s    = row_r;
    accept_s = 1'b0;
    enter_s  = 1'b0;
    load_s   = 1'b0;
    last_s   = 1'b0;
    drop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          best_s   = '0;
          k_s      = MODE_W'(1);
          row_s    = '0;
          if (NMODES == 1) begin
            state_s = WRITE;
            enter_s = 1'b1;
            load_s  = 1'b1;
          end else begin
            state_s = SCAN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        // Strict less-than: ties keep the lower mode index.
        if (sads_r[int'(k_r)*SAD_W +: SAD_W] < sads_r[int'(best_r)*SAD_W +: SAD_W]) begin
          best_s = k_r;
        end else begin
          best_s = best_r;
        end
        k_s = k_r + MODE_W'(1);
        if (k_r == MODE_W'(NMODES - 1)) begin
          state_s = WRITE;
          enter_s = 1'b1;
          load_s  = 1'b1;
          row_s   = '0;
        end else begin
          state_s = SCAN;
        end
      end
      WRITE: begin
        if (oor_r) begin
          state_s = IDLE;
          drop_s  = 1'b1;
        end else if (wr_valid_r && wr_ready) begin
          if (row_r == RW_W'(BLK - 1)) begin
            state_s = IDLE;
            last_s  = 1'b1;
          end else begin
            row_s  = row_r + RW_W'(1);
            load_s = 1'b1;
          end
        end else begin
          state_s = WRITE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Source selection, block-origin address and next write-port contents
  always_comb begin
    blk_sel_s = (state_r == IDLE) ? blk_num  : blk_r;
    res_sel_s = (state_r == IDLE) ? residues : res_r;
    oor_in_s  = {1'b0, blk_num} >= NBLK_V;
    oor_sel_s = (state_r == IDLE) ? oor_in_s : oor_r;
    bx_s      = {1'b0, blk_sel_s} % BPR_V;
    by_s      = {1'b0, blk_sel_s} / BPR_V;
    base_s    = AD_W'(by_s) * AD_W'(BLK * FRAME_W) + AD_W'(bx_s) * AD_W'(BLK);
    addr_s    = enter_s ? base_s : (wr_addr_r + AD_W'(FRAME_W));
    data_s    = row_of(res_sel_s, best_s, row_s);
  end

  // Control state, write port and completion outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      in_ready_r   <= 1'b1;
      best_r       <= '0;
      k_r          <= '0;
      row_r        <= '0;
      oor_r        <= 1'b0;
      wr_valid_r   <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
      mode_valid_r <= 1'b0;
      mode_r       <= '0;
      mode_blk_r   <= '0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      in_ready_r   <= (state_s == IDLE);
      best_r       <= best_s;
      k_r          <= k_s;
      row_r        <= row_s;
      mode_valid_r <= last_s;
      err_r        <= drop_s;
      if (accept_s) begin
        oor_r <= oor_in_s;
      end
      if (load_s) begin
        wr_addr_r <= addr_s;
        wr_data_r <= data_s;
      end
      if (enter_s) begin
        wr_valid_r <= !oor_sel_s;
      end else if (last_s) begin
        wr_valid_r <= 1'b0;
      end
      if (last_s) begin
        mode_r     <= best_r;
        mode_blk_r <= blk_r;
      end
    end
  end

  // Block capture; contents only matter once a block is accepted
  always_ff @(posedge clk) begin
    if (accept_s) begin
      sads_r <= sads;
      res_r  <= residues;
      blk_r  <= blk_num;
    end
  end

  // Mode table write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (!reset && last_s) begin
      mtab_r[blk_r] <= best_r;
    end
  end

  // Registered table read, old data on a same-address write
  always_ff @(posedge clk) begin
    if (reset) begin
      mtab_rdata_r <= '0;
    end else begin
      mtab_rdata_r <= mtab_r[mtab_raddr];
    end
  end

  assign in_ready   = in_ready_r;
  assign wr_valid   = wr_valid_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign mode_valid = mode_valid_r;
  assign mode       = mode_r;
  assign mode_blk   = mode_blk_r;
  assign err        = err_r;
  assign mtab_rdata = mtab_rdata_r;

endmodule
